// File: rtl/ram16x16_fifo_ctrl.sv
// ram16x16_fifo_ctrl: drives a single-port RAM16x16 so it behaves as a
// 16-deep FIFO with a one-word output register in front of the consumer.
// Ports: clk, reset_n (async, active-low);
//   s_data/s_valid/s_ready : write stream (s_ready is combinational)
//   m_data/m_valid/m_ready : read stream (m_data is a held register)
//   ram_data_in/ram_addr_in/ram_cs/ram_w_en/ram_op_en : registered RAM strobes
//   ram_data_out : RAM read data
//   count (RAM words + output register), full, empty
// Optional: define ALMOST_FLAGS_EN to add registered almost_full/almost_empty
//   (thresholds AF_TH on RAM occupancy, AE_TH on count).
module ram16x16_fifo_ctrl #(
  parameter int DW     = 16,
  parameter int AW     = 4,
  parameter int RD_LAT = 1
`ifdef ALMOST_FLAGS_EN
  ,
  parameter int AF_TH  = 14,
  parameter int AE_TH  = 2
`endif
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] ram_data_in,
  output logic [AW-1:0] ram_addr_in,
  output logic          ram_cs,
  output logic          ram_w_en,
  output logic          ram_op_en,
  input  logic [DW-1:0] ram_data_out,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
`ifdef ALMOST_FLAGS_EN
  ,
  output logic          almost_full,
  output logic          almost_empty
`endif
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 1;
  localparam int LW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RD_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] ram_count_q, ram_count_d;
  logic [LW-1:0] wait_q, wait_d;

  logic          m_valid_q, m_valid_d;
  logic [DW-1:0] m_data_q, m_data_d;

  logic          ram_cs_q, ram_cs_d;
  logic          ram_w_en_q, ram_w_en_d;
  logic          ram_op_en_q, ram_op_en_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;

  logic          full_w;
  logic [CW-1:0] count_w;
  logic          rd_go;
  logic          wr_go;

  assign full_w  = (ram_count_q == CW'(DEPTH));
  assign count_w = ram_count_q + CW'(m_valid_q);

  // Reads win: the output register is refilled before more data is
  // accepted, and only one RAM access may be issued per cycle.
  assign rd_go = (ram_count_q != '0) && !m_valid_q;
  assign wr_go = !rd_go && s_valid && !full_w;

  assign s_ready = (state_q == IDLE) && wr_go;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q;
    wait_d      = wait_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    ram_cs_d    = 1'b0;
    ram_w_en_d  = 1'b0;
    ram_op_en_d = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (rd_go) begin
          state_d     = RD;
          ram_cs_d    = 1'b1;
          ram_op_en_d = 1'b1;
          ram_addr_d  = rd_ptr_q;
          rd_ptr_d    = rd_ptr_q + AW'(1);
          ram_count_d = ram_count_q - CW'(1);
        end else if (wr_go) begin
          state_d     = WR;
          ram_cs_d    = 1'b1;
          ram_w_en_d  = 1'b1;
          ram_addr_d  = wr_ptr_q;
          ram_wdata_d = s_data;
          wr_ptr_d    = wr_ptr_q + AW'(1);
          ram_count_d = ram_count_q + CW'(1);
        end
      end
      WR: begin
        state_d = IDLE;
      end
      RD: begin
        state_d = RD_WAIT;
        wait_d  = LW'(RD_LAT - 1);
      end
      RD_WAIT: begin
        if (wait_q == '0) begin
          m_data_d  = ram_data_out;
          m_valid_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wait_d = wait_q - LW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      wait_q      <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      ram_cs_q    <= 1'b0;
      ram_w_en_q  <= 1'b0;
      ram_op_en_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      wait_q      <= wait_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      ram_cs_q    <= ram_cs_d;
      ram_w_en_q  <= ram_w_en_d;
      ram_op_en_q <= ram_op_en_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign ram_data_in = ram_wdata_q;
  assign ram_addr_in = ram_addr_q;
  assign ram_cs      = ram_cs_q;
  assign ram_w_en    = ram_w_en_q;
  assign ram_op_en   = ram_op_en_q;
  assign count       = count_w;
  assign full        = full_w;
  assign empty       = (count_w == '0);

`ifdef ALMOST_FLAGS_EN
  logic afull_q, afull_d;
  logic aempty_q, aempty_d;

  // Flags follow the current occupancy, so they settle one edge
  // after the count changes.
  always_comb begin
    afull_d  = (ram_count_q >= CW'(AF_TH));
    aempty_d = (count_w <= CW'(AE_TH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
`endif

endmodule

// File: tb/tb_ram16x16_fifo_ctrl.sv
// tb_ram16x16_fifo_ctrl: self-checking bench with a RAM16x16 model,
// a cycle table for one word in and out, and a queue scoreboard.
module tb_ram16x16_fifo_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] ram_data_in;
  logic [3:0]  ram_addr_in;
  logic        ram_cs;
  logic        ram_w_en;
  logic        ram_op_en;
  logic [15:0] ram_data_out = 16'h0;
  logic [4:0]  count;
  logic        full;
  logic        empty;
`ifdef ALMOST_FLAGS_EN
  logic        almost_full;
  logic        almost_empty;
`endif

  always #5 clk = ~clk;

  ram16x16_fifo_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .ram_data_in  (ram_data_in),
    .ram_addr_in  (ram_addr_in),
    .ram_cs       (ram_cs),
    .ram_w_en     (ram_w_en),
    .ram_op_en    (ram_op_en),
    .ram_data_out (ram_data_out),
    .count        (count),
    .full         (full),
    .empty        (empty)
`ifdef ALMOST_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  // RAM16x16: write on cs&w_en, registered read on cs&op_en.
  logic [15:0] mem [16];
  always @(posedge clk) begin
    if (ram_cs && ram_w_en) mem[ram_addr_in] <= ram_data_in;
    else if (ram_cs && ram_op_en) ram_data_out <= mem[ram_addr_in];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: FIFO order of accepted words vs delivered words.
  logic [15:0] sb[$];
  int          n_deliv = 0;
  int          n_wraps = 0;
  int          last_wa = 0;
  bit          mon_en  = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && reset_n) begin
        chk("single_access", {31'd0, ram_w_en & ram_op_en}, 32'd0);
        if (ram_cs && ram_w_en) begin
          if (ram_addr_in == 4'd0 && last_wa == 15) n_wraps++;
          last_wa = int'(ram_addr_in);
        end
        if (s_valid && s_ready) sb.push_back(s_data);
        if (m_valid && m_ready) begin
          n_deliv++;
          if (sb.size() == 0) chk("order_underflow", {16'd0, m_data}, 32'hFFFF_FFFF);
          else chk("order", {16'd0, m_data}, {16'd0, sb.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, output bit ok);
    s_valid = 1'b1;
    s_data  = d;
    ok      = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = s_ready;
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    m_ready = 1'b1;
    repeat (120) tick();
    chk(nm, {27'd0, count}, 32'd0);
    chk({nm, "_empty"}, {31'd0, empty}, 32'd1);
    m_ready = 1'b0;
  endtask

  typedef struct {
    logic        sv;
    logic [15:0] sd;
    logic        mr;
    logic        rdy;
    logic        cs;
    logic        we;
    logic        oe;
    logic [3:0]  addr;
    logic        mv;
    logic [15:0] md;
    logic [4:0]  cnt;
  } vec_t;

  vec_t tbl[11];
  bit   ok;
  int   base;
  int   wr0;
  bit   prod_done;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // sv sd mr | rdy cs we oe addr mv md cnt
    tbl[0]  = '{1'b1, 16'hA5A5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 5'd1};
    tbl[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 5'd1};
    tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 16'h0000, 5'd0};
    tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 5'd0};
    tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 16'hA5A5, 5'd1};
    tbl[5]  = '{1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 16'hA5A5, 5'd2};
    tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 16'hA5A5, 5'd1};
    tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 16'hA5A5, 5'd0};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 16'hA5A5, 5'd0};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 16'h1234, 5'd1};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 16'h1234, 5'd0};

    reset_n = 1'b0;
    s_valid = 1'b0;
    s_data  = 16'h0;
    m_ready = 1'b0;
    repeat (3) tick();
    chk("rst_cs", {31'd0, ram_cs}, 32'd0);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_mvalid", {31'd0, m_valid}, 32'd0);
    chk("rst_mdata", {16'd0, m_data}, 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      s_valid = tbl[i].sv;
      s_data  = tbl[i].sd;
      m_ready = tbl[i].mr;
      @(negedge clk);
      chk($sformatf("t%0d_s_ready", i), {31'd0, s_ready}, {31'd0, tbl[i].rdy});
      tick();
      chk($sformatf("t%0d_cs", i), {31'd0, ram_cs}, {31'd0, tbl[i].cs});
      chk($sformatf("t%0d_w_en", i), {31'd0, ram_w_en}, {31'd0, tbl[i].we});
      chk($sformatf("t%0d_op_en", i), {31'd0, ram_op_en}, {31'd0, tbl[i].oe});
      if (tbl[i].cs)
        chk($sformatf("t%0d_addr", i), {28'd0, ram_addr_in}, {28'd0, tbl[i].addr});
      chk($sformatf("t%0d_m_valid", i), {31'd0, m_valid}, {31'd0, tbl[i].mv});
      chk($sformatf("t%0d_m_data", i), {16'd0, m_data}, {16'd0, tbl[i].md});
      chk($sformatf("t%0d_count", i), {27'd0, count}, {27'd0, tbl[i].cnt});
    end
    s_valid = 1'b0;
    m_ready = 1'b0;

    // Asynchronous reset while a write strobe is out.
    s_valid = 1'b1;
    s_data  = 16'hBEEF;
    tick();
    s_valid = 1'b0;
    chk("mid_wr_cs_pre", {31'd0, ram_cs & ram_w_en}, 32'd1);
    #2;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("arst_cs", {31'd0, ram_cs}, 32'd0);
    chk("arst_w_en", {31'd0, ram_w_en}, 32'd0);
    chk("arst_op_en", {31'd0, ram_op_en}, 32'd0);
    chk("arst_addr", {28'd0, ram_addr_in}, 32'd0);
    chk("arst_data", {16'd0, ram_data_in}, 32'd0);
    chk("arst_count", {27'd0, count}, 32'd0);
    chk("arst_empty", {31'd0, empty}, 32'd1);
    chk("arst_mvalid", {31'd0, m_valid}, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    sb.delete();
    last_wa = 0;
    mon_en  = 1'b1;
    tick();

    // Fill: 16 words in RAM plus one in the output register.
    base = n_deliv;
    for (int w = 1; w <= 17; w++) begin
      push(16'(w), ok);
      chk($sformatf("fill_acc_%0d", w), {31'd0, ok}, 32'd1);
    end
    repeat (4) tick();
    chk("fill_count", {27'd0, count}, 32'd17);
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_empty", {31'd0, empty}, 32'd0);
    chk("fill_mvalid", {31'd0, m_valid}, 32'd1);
    chk("fill_mdata", {16'd0, m_data}, 32'd1);
    s_valid = 1'b1;
    s_data  = 16'h0012;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_s_ready", {31'd0, s_ready}, 32'd0);
      tick();
    end
    s_valid = 1'b0;
    drain("fill_drain");
    chk("fill_delivered", n_deliv - base, 32'd17);

    // Backpressure: held output word, one more waiting in RAM.
    push(16'hC001, ok);
    chk("bp_acc1", {31'd0, ok}, 32'd1);
    push(16'hC002, ok);
    chk("bp_acc2", {31'd0, ok}, 32'd1);
    tick();
    chk("bp_count", {27'd0, count}, 32'd2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_mdata", {16'd0, m_data}, 32'hC001);
      chk("bp_mvalid", {31'd0, m_valid}, 32'd1);
      chk("bp_op_en", {31'd0, ram_op_en}, 32'd0);
      tick();
    end
    drain("bp_drain");

    // Random push/pop across pointer wrap.
    base      = n_deliv;
    wr0       = n_wraps;
    prod_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          push(16'h2000 + 16'(i), ok);
          chk("wrap_acc", {31'd0, ok}, 32'd1);
          repeat ($urandom_range(0, 2)) tick();
        end
        prod_done = 1'b1;
      end
      begin
        for (int c = 0; c < 3000; c++) begin
          if (prod_done && sb.size() == 0 && !m_valid) break;
          m_ready = 1'($urandom_range(0, 1));
          tick();
        end
        m_ready = 1'b0;
      end
    join
    chk("wrap_delivered", n_deliv - base, 32'd40);
    chk("wrap_left", sb.size(), 32'd0);
    chk("wrap_addr_wrapped", {31'd0, (n_wraps > wr0)}, 32'd1);

`ifdef ALMOST_FLAGS_EN
    for (int w = 0; w < 14; w++) push(16'h3000 + 16'(w), ok);
    repeat (3) tick();
    chk("af_before", {31'd0, almost_full}, 32'd0);
    push(16'h300E, ok);
    repeat (2) tick();
    chk("af_after", {31'd0, almost_full}, 32'd1);
    chk("ae_high", {31'd0, almost_empty}, 32'd0);
    for (int c = 0; c < 200; c++) begin
      m_ready = (count > 5'd2);
      tick();
    end
    m_ready = 1'b0;
    repeat (2) tick();
    chk("ae_count", {27'd0, count}, 32'd2);
    chk("ae_flag", {31'd0, almost_empty}, 32'd1);
    drain("af_drain");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
